// File: rtl/multi_control_pkg.sv
// Shared encodings for the multicycle MIPS control slice: FSM states,
// instruction fields, ALU operation codes and ALU B-operand selectors.
package multi_control_pkg;

   typedef logic [3:0] alu_op_t;
   typedef logic [1:0] src_b_t;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLL = 6'b000000;

   localparam alu_op_t ALU_AND = 4'b0000;
   localparam alu_op_t ALU_OR  = 4'b0001;
   localparam alu_op_t ALU_ADD = 4'b0010;
   localparam alu_op_t ALU_SLL = 4'b0011;
   localparam alu_op_t ALU_SUB = 4'b0110;

   localparam src_b_t SRCB_B      = 2'b00;
   localparam src_b_t SRCB_FOUR   = 2'b01;
   localparam src_b_t SRCB_IMM    = 2'b10;
   localparam src_b_t SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/multi_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath
// (slave): instruction fields and ALU flag in, per-cycle strobes out.
interface multi_control_if;
   import multi_control_pkg::*;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       pc_write;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   src_b_t     alu_src_b;
   logic       pc_source;
   alu_op_t    alu_operation;
   logic       instr_done;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  opcode, funct, zero,
      output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
             alu_operation, instr_done, illegal, state
   );

   modport slave (
      output opcode, funct, zero,
      input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
             alu_operation, instr_done, illegal, state
   );

endinterface

// File: rtl/multi_control_alu_decoder.sv
// R-type funct to ALU operation mapping; unsupported functs flag illegal
// and fall back to add so the ALU input is never undefined.
module alu_decoder
   import multi_control_pkg::*;
(
   input  logic [5:0] funct,
   output alu_op_t    alu_operation,
   output logic       illegal
);

   // funct decode
   always_comb begin
      alu_operation = ALU_ADD;
      illegal       = 1'b0;
      case (funct)
         FN_ADD:  alu_operation = ALU_ADD;
         FN_AND:  alu_operation = ALU_AND;
         FN_OR:   alu_operation = ALU_OR;
         FN_SLL:  alu_operation = ALU_SLL;
         default: illegal       = 1'b1;
      endcase
   end

endmodule

// File: rtl/multi_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes the state into datapath strobes for a shared ALU and memory port.
module multi_control
   import multi_control_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   multi_control_if.master ctl
);

   state_t  state_r;
   state_t  next_state_s;

   logic    pc_write_s;
   logic    i_or_d_s;
   logic    mem_read_s;
   logic    mem_write_s;
   logic    ir_write_s;
   logic    reg_dst_s;
   logic    mem_to_reg_s;
   logic    reg_write_s;
   logic    alu_src_a_s;
   src_b_t  alu_src_b_s;
   logic    pc_source_s;
   alu_op_t alu_op_s;
   logic    instr_done_s;
   logic    illegal_s;

   alu_op_t funct_op_s;
   logic    funct_illegal_s;

   alu_decoder u_alu_decoder (
      .funct         (ctl.funct),
      .alu_operation (funct_op_s),
      .illegal       (funct_illegal_s)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // next-state and per-state strobe decode
   always_comb begin
      next_state_s = S_FETCH;
      pc_write_s   = 1'b0;
      i_or_d_s     = 1'b0;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      ir_write_s   = 1'b0;
      reg_dst_s    = 1'b0;
      mem_to_reg_s = 1'b0;
      reg_write_s  = 1'b0;
      alu_src_a_s  = 1'b0;
      alu_src_b_s  = SRCB_B;
      pc_source_s  = 1'b0;
      alu_op_s     = ALU_ADD;
      instr_done_s = 1'b0;
      illegal_s    = 1'b0;
      case (state_r)
         S_FETCH: begin
            mem_read_s   = 1'b1;
            ir_write_s   = 1'b1;
            alu_src_b_s  = SRCB_FOUR;
            pc_write_s   = 1'b1;
            next_state_s = S_DECODE;
         end
         S_DECODE: begin
            // branch target is precomputed into ALUOut here
            alu_src_b_s = SRCB_IMM_SH;
            case (ctl.opcode)
               OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
               OP_BEQ:       next_state_s = S_BRANCH;
               OP_RTYPE: begin
                  if (funct_illegal_s) begin
                     illegal_s    = 1'b1;
                     instr_done_s = 1'b1;
                     next_state_s = S_FETCH;
                  end else begin
                     next_state_s = S_EXECUTE;
                  end
               end
               default: begin
                  illegal_s    = 1'b1;
                  instr_done_s = 1'b1;
                  next_state_s = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = SRCB_IMM;
            if (ctl.opcode == OP_LW) begin
               next_state_s = S_MEM_READ;
            end else if (ctl.opcode == OP_SW) begin
               next_state_s = S_MEM_WRITE;
            end else begin
               next_state_s = S_FETCH;
            end
         end
         S_MEM_READ: begin
            mem_read_s   = 1'b1;
            i_or_d_s     = 1'b1;
            next_state_s = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write_s  = 1'b1;
            mem_to_reg_s = 1'b1;
            instr_done_s = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write_s  = 1'b1;
            i_or_d_s     = 1'b1;
            instr_done_s = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a_s  = 1'b1;
            alu_op_s     = funct_op_s;
            next_state_s = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write_s  = 1'b1;
            reg_dst_s    = 1'b1;
            instr_done_s = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_s  = 1'b1;
            alu_op_s     = ALU_SUB;
            pc_source_s  = 1'b1;
            pc_write_s   = ctl.zero;
            instr_done_s = 1'b1;
         end
         default: begin
            // unreachable encodings drive nothing and recover via FETCH
            alu_op_s = 4'b0000;
         end
      endcase
   end

   // reset masks every strobe so no write escapes an aborted instruction
   always_comb begin
      ctl.state = state_r;
      if (reset) begin
         ctl.pc_write      = 1'b0;
         ctl.i_or_d        = 1'b0;
         ctl.mem_read      = 1'b0;
         ctl.mem_write     = 1'b0;
         ctl.ir_write      = 1'b0;
         ctl.reg_dst       = 1'b0;
         ctl.mem_to_reg    = 1'b0;
         ctl.reg_write     = 1'b0;
         ctl.alu_src_a     = 1'b0;
         ctl.alu_src_b     = 2'b00;
         ctl.pc_source     = 1'b0;
         ctl.alu_operation = 4'b0000;
         ctl.instr_done    = 1'b0;
         ctl.illegal       = 1'b0;
      end else begin
         ctl.pc_write      = pc_write_s;
         ctl.i_or_d        = i_or_d_s;
         ctl.mem_read      = mem_read_s;
         ctl.mem_write     = mem_write_s;
         ctl.ir_write      = ir_write_s;
         ctl.reg_dst       = reg_dst_s;
         ctl.mem_to_reg    = mem_to_reg_s;
         ctl.reg_write     = reg_write_s;
         ctl.alu_src_a     = alu_src_a_s;
         ctl.alu_src_b     = alu_src_b_s;
         ctl.pc_source     = pc_source_s;
         ctl.alu_operation = alu_op_s;
         ctl.instr_done    = instr_done_s;
         ctl.illegal       = illegal_s;
      end
   end

endmodule

// File: tb/tb_multi_control.sv
// Directed bench for multi_control: walks each instruction class through the
// FSM and compares state sequence and strobes against hand-derived values.
module tb_multi_control;

   typedef struct packed {
      logic       pc_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       pc_source;
      logic [3:0] alu_operation;
      logic       instr_done;
      logic       illegal;
   } outs_t;

   logic  clk;
   logic  reset;
   int    checks_r;
   int    errors_r;
   outs_t snap_r [0:4];
   int    done_cnt_r;
   int    ill_cnt_r;
   int    rw_cnt_r;
   int    mw_cnt_r;

   multi_control_if bus ();

   multi_control dut (
      .clk   (clk),
      .reset (reset),
      .ctl   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic outs_t capture();
      outs_t o;
      o.pc_write      = bus.pc_write;
      o.i_or_d        = bus.i_or_d;
      o.mem_read      = bus.mem_read;
      o.mem_write     = bus.mem_write;
      o.ir_write      = bus.ir_write;
      o.reg_dst       = bus.reg_dst;
      o.mem_to_reg    = bus.mem_to_reg;
      o.reg_write     = bus.reg_write;
      o.alu_src_a     = bus.alu_src_a;
      o.alu_src_b     = bus.alu_src_b;
      o.pc_source     = bus.pc_source;
      o.alu_operation = bus.alu_operation;
      o.instr_done    = bus.instr_done;
      o.illegal       = bus.illegal;
      return o;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_r++;
      if (obs !== exp) begin
         errors_r++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Runs one instruction from FETCH; exp_states holds one nibble per cycle, cycle 0 lowest.
   task automatic run_instr(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                            input logic z, input int ncyc, input logic [19:0] exp_states);
      outs_t o;
      bus.opcode = opc;
      bus.funct  = fn;
      bus.zero   = z;
      done_cnt_r = 0;
      ill_cnt_r  = 0;
      rw_cnt_r   = 0;
      mw_cnt_r   = 0;
      #1;
      for (int k = 0; k < ncyc; k++) begin
         check_eq({tag, "_state"}, {28'd0, bus.state}, {28'd0, exp_states[4*k +: 4]});
         o = capture();
         snap_r[k] = o;
         done_cnt_r += int'(o.instr_done);
         ill_cnt_r  += int'(o.illegal);
         rw_cnt_r   += int'(o.reg_write);
         mw_cnt_r   += int'(o.mem_write);
         tick();
      end
      check_eq({tag, "_back_to_fetch"}, {28'd0, bus.state}, 32'd0);
      check_eq({tag, "_done_pulses"}, done_cnt_r, 32'd1);
   endtask

   initial begin
      checks_r    = 0;
      errors_r    = 0;
      reset       = 1'b1;
      bus.opcode  = 6'b000000;
      bus.funct   = 6'b100000;
      bus.zero    = 1'b0;

      // reset held three cycles: every strobe masked
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("reset_strobes", {14'd0, capture()}, 32'd0);
         check_eq("reset_state", {28'd0, bus.state}, 32'd0);
      end
      reset = 1'b0;
      #1;
      check_eq("fetch_pc_write", {31'd0, bus.pc_write}, 32'd1);
      check_eq("fetch_ir_write", {31'd0, bus.ir_write}, 32'd1);
      check_eq("fetch_mem_read", {31'd0, bus.mem_read}, 32'd1);
      check_eq("fetch_src_b", {30'd0, bus.alu_src_b}, 32'd1);
      check_eq("fetch_alu_op", {28'd0, bus.alu_operation}, 32'h2);

      // R-type add
      run_instr("add", 6'b000000, 6'b100000, 1'b0, 4, 20'h07610);
      check_eq("add_decode_src_b", {30'd0, snap_r[1].alu_src_b}, 32'd3);
      check_eq("add_exec_alu_op", {28'd0, snap_r[2].alu_operation}, 32'h2);
      check_eq("add_exec_src_a", {31'd0, snap_r[2].alu_src_a}, 32'd1);
      check_eq("add_wb_reg_write", {31'd0, snap_r[3].reg_write}, 32'd1);
      check_eq("add_wb_reg_dst", {31'd0, snap_r[3].reg_dst}, 32'd1);
      check_eq("add_illegal", ill_cnt_r, 32'd0);

      // other R-type functs
      run_instr("or", 6'b000000, 6'b100101, 1'b0, 4, 20'h07610);
      check_eq("or_alu_op", {28'd0, snap_r[2].alu_operation}, 32'h1);
      run_instr("and", 6'b000000, 6'b100100, 1'b0, 4, 20'h07610);
      check_eq("and_alu_op", {28'd0, snap_r[2].alu_operation}, 32'h0);
      run_instr("sll", 6'b000000, 6'b000000, 1'b0, 4, 20'h07610);
      check_eq("sll_alu_op", {28'd0, snap_r[2].alu_operation}, 32'h3);

      // lw then sw
      run_instr("lw", 6'b100011, 6'b000000, 1'b0, 5, 20'h43210);
      check_eq("lw_addr_src_b", {30'd0, snap_r[2].alu_src_b}, 32'd2);
      check_eq("lw_read_i_or_d", {31'd0, snap_r[3].i_or_d}, 32'd1);
      check_eq("lw_read_mem_read", {31'd0, snap_r[3].mem_read}, 32'd1);
      check_eq("lw_wb_mem_to_reg", {31'd0, snap_r[4].mem_to_reg}, 32'd1);
      check_eq("lw_wb_reg_write", {31'd0, snap_r[4].reg_write}, 32'd1);
      check_eq("lw_wb_reg_dst", {31'd0, snap_r[4].reg_dst}, 32'd0);
      run_instr("sw", 6'b101011, 6'b000000, 1'b0, 4, 20'h05210);
      check_eq("sw_mem_write", {31'd0, snap_r[3].mem_write}, 32'd1);
      check_eq("sw_i_or_d", {31'd0, snap_r[3].i_or_d}, 32'd1);
      check_eq("sw_no_reg_write", rw_cnt_r, 32'd0);

      // beq taken and not taken
      run_instr("beq_t", 6'b000100, 6'b000000, 1'b1, 3, 20'h00810);
      check_eq("beq_t_pc_write", {31'd0, snap_r[2].pc_write}, 32'd1);
      check_eq("beq_t_pc_source", {31'd0, snap_r[2].pc_source}, 32'd1);
      check_eq("beq_t_alu_op", {28'd0, snap_r[2].alu_operation}, 32'h6);
      run_instr("beq_n", 6'b000100, 6'b000000, 1'b0, 3, 20'h00810);
      check_eq("beq_n_pc_write", {31'd0, snap_r[2].pc_write}, 32'd0);

      // illegal opcode, then illegal funct
      run_instr("ill_op", 6'b111111, 6'b100000, 1'b0, 2, 20'h00010);
      check_eq("ill_op_flag", {31'd0, snap_r[1].illegal}, 32'd1);
      check_eq("ill_op_writes", rw_cnt_r + mw_cnt_r, 32'd0);
      run_instr("ill_fn", 6'b000000, 6'b101010, 1'b0, 2, 20'h00010);
      check_eq("ill_fn_flag", {31'd0, snap_r[1].illegal}, 32'd1);
      check_eq("ill_fn_writes", rw_cnt_r + mw_cnt_r, 32'd0);

      // lw aborted by reset in MEM_READ
      bus.opcode = 6'b100011;
      bus.funct  = 6'b000000;
      rw_cnt_r   = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         rw_cnt_r += int'(bus.reg_write);
      end
      check_eq("abort_in_mem_read", {28'd0, bus.state}, 32'd3);
      reset = 1'b1;
      #1;
      check_eq("abort_masked", {14'd0, capture()}, 32'd0);
      tick();
      check_eq("abort_state_fetch", {28'd0, bus.state}, 32'd0);
      rw_cnt_r += int'(bus.reg_write);
      bus.opcode = 6'b101011;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         rw_cnt_r += int'(bus.reg_write);
         tick();
      end
      check_eq("abort_no_reg_write", rw_cnt_r, 32'd0);
      check_eq("abort_resume_fetch", {28'd0, bus.state}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
      $finish;
   end

endmodule
